uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the UART bus controller.
- Captures each byte the receiver completes (rx_end pulse with rx_data).
- Holds bytes in a circular FIFO and presents the oldest byte first-word-fall-through to the controller's pop interface.
- Raises a level interrupt on a programmable threshold and a sticky overrun flag on dropped bytes.
- Decouples software read latency from line rate so back-to-back frames are not lost.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
PTR_W, 4, log2(DEPTH); pointer width
DATA_W, 8, byte width; matches receiver data width
TIMEOUT_CYC, 4096, idle cycles before timeout interrupt (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset, sampled on rising clk
rx_end  in  1  one-cycle pulse: receiver completed a byte
rx_data  in  DATA_W  received byte, valid when rx_end=1
pop  in  1  controller consumes head byte this cycle
rd_data  out  DATA_W  head byte (FWFT); 0 when empty
empty  out  1  FIFO holds zero bytes
full  out  1  FIFO holds DEPTH bytes
count  out  PTR_W+1  current occupancy, 0..DEPTH
level_thr  in  PTR_W+1  interrupt threshold; 0 disables
irq_level  out  1  count >= level_thr and level_thr != 0
overrun  out  1  sticky: byte dropped because FIFO full
ovr_clr  in  1  clears overrun
flush  in  1  discard all contents
irq_timeout  out  1  only with UART_RX_FIFO_TIMEOUT_EN

Behaviour:
- Reset (reset=0 at clk edge): wr_ptr=0, rd_ptr=0, count=0, overrun=0, timeout counter=0. Outputs: empty=1, full=0, rd_data=0, irq_level=0, irq_timeout=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored bytes. The first push after reset release lands in entry 0.
- Push: rx_end=1 and (not full, or pop accepted in the same cycle). The byte is written at wr_ptr, wr_ptr advances modulo DEPTH, and count updates at the next edge.
- Pop: pop=1 and not empty. rd_ptr advances modulo DEPTH. pop while empty is ignored; no state changes.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, the pop frees a slot and the push is accepted; no overrun.
  - When empty, the pop is ignored and the push is accepted; count becomes 1.
- rd_data = mem[rd_ptr] combinationally when count != 0, else 0.
- Latency: a byte pushed at edge N is visible on rd_data, with empty=0, after edge N.
- Overrun: rx_end=1 and full and no pop. The byte is dropped, pointers are untouched, and overrun=1 at the next edge.
- overrun holds until ovr_clr=1. If a set and a clear occur in the same cycle, the set wins.
- Flush: wr_ptr=rd_ptr=0 and count=0 at the next edge. Flush has priority over push and pop in the same cycle; a byte arriving that cycle is discarded without setting overrun. overrun is unaffected by flush.
- empty, full, and irq_level are decoded combinationally from the registered count.
- Pointers wrap DEPTH-1 -> 0. full/empty are decided from count, never from pointer equality alone.

Optional Feature:
Macro: UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter clears on push, pop, flush, or reset, and increments each cycle while count != 0.
  - When it reaches TIMEOUT_CYC-1, irq_timeout=1. It stays high and the counter saturates until the next push, pop, or flush.
  - While empty, the counter holds at 0.
- Not defined: irq_timeout port and counter are absent; no timeout logic is synthesized.

Decomposition:
- Shared header with the other UART blocks:
  - UART_DATA_W (8).
  - UART_RX_FIFO_DEPTH / UART_RX_FIFO_PTR_W default constants.
  - UART_RX_FIFO_TIMEOUT_EN default (undefined).
- One sub-module: uart_fifo_ram, a DEPTH x DATA_W storage array with a synchronous write port and an asynchronous read port. It holds no control logic.
- Pointer/count/flag control stays in uart_rx_fifo.

Test Plan:
- Reset, then 3 pushes 0xA1, 0xB2, 0xC3 -> count=3, rd_data=0xA1. Three pops -> rd_data 0xB2, 0xC3, then empty=1, rd_data=0.
- Fill 16 bytes 0x00..0x0F, then push 0xFF with no pop -> full=1, overrun=1, count=16. Pops return 0x00..0x0F and 0xFF is never seen. ovr_clr -> overrun=0.
- Full FIFO, rx_end=1 with 0x55 and pop=1 same cycle -> count stays 16, overrun=0. 0x55 emerges 16 pops later.
- level_thr=4, push 4 bytes -> irq_level rises the cycle count=4. One pop -> irq_level=0. level_thr=0 with full FIFO -> irq_level=0.
- 5 bytes stored, flush=1 with rx_end=1 same cycle -> count=0, empty=1, overrun unchanged. The next push appears at rd_data.
- Feature on, TIMEOUT_CYC=16, push 1 byte and idle -> irq_timeout=1 exactly 15 cycles after the push cycle. pop -> irq_timeout=0 next edge. Reset mid-count -> irq_timeout=0 and count=0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: byte width and receive FIFO geometry defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Optional feature macro UART_RX_FIFO_TIMEOUT_EN is left undefined by default.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W              = 8;
    localparam int UART_RX_FIFO_DEPTH       = 16;
    localparam int UART_RX_FIFO_PTR_W       = 4;
    localparam int UART_RX_FIFO_TIMEOUT_CYC = 4096;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_fifo_ram.sv
// Byte storage array for the UART receive FIFO; no control logic.
// Latency: write lands at the clock edge, read is combinational from address.
// Backpressure: none; the caller decides when a write is legal.
// Ports: i_clk, i_we/i_waddr/i_wdata (synchronous write), i_raddr/o_rdata (async read).
module uart_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int PTR_W  = UART_RX_FIFO_PTR_W,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are intentionally not reset; occupancy tracking lives in the parent.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between UART receiver and bus controller, first-word-fall-through.
// Latency: byte pushed at edge N is on o_rd_data (o_empty=0) right after edge N.
// Backpressure: none upstream; a byte arriving while full with no pop is dropped and flags overrun.
// Ports: i_clk, i_reset (sync, active-low), i_rx_end/i_rx_data (push), i_pop/o_rd_data (FWFT pop),
//        o_empty/o_full/o_count (occupancy), i_level_thr/o_irq_level, o_overrun/i_ovr_clr, i_flush,
//        o_irq_timeout (only when UART_RX_FIFO_TIMEOUT_EN is defined).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int PTR_W  = UART_RX_FIFO_PTR_W,
    parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = UART_RX_FIFO_TIMEOUT_CYC
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_end,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [PTR_W:0]    o_count,
    input  logic [PTR_W:0]    i_level_thr,
    output logic              o_irq_level,
    output logic              o_overrun,
    input  logic              i_ovr_clr,
    input  logic              i_flush
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    output logic              o_irq_timeout
`endif
);

    localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_overrun;

    logic              w_empty;
    logic              w_full;
    logic              w_do_pop;
    logic              w_do_push;
    logic              w_ovr_set;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_FULL);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_do_push = i_rx_end && (!w_full || w_do_pop);
    // Bytes discarded by a flush are not counted as overrun.
    assign w_ovr_set = i_rx_end && w_full && !i_pop && !i_flush;
    assign w_ram_we  = w_do_push && !i_flush;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // Pointers are PTR_W wide with DEPTH a power of two, so increment wraps DEPTH-1 -> 0.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_rd_data   = w_empty ? '0 : w_ram_rdata;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_count;
    assign o_irq_level = (i_level_thr != '0) && (r_count >= i_level_thr);
    assign o_overrun   = r_overrun;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int             TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] LP_TO_MAX = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_idle;
    logic            w_activity;

    assign w_activity = w_do_push || w_do_pop || i_flush;

    // Idle counter saturates at the threshold so the interrupt stays up until activity.
    always_ff @(posedge i_clk) begin
        if (!i_reset || w_activity || w_empty) begin
            r_idle <= '0;
        end else if (r_idle != LP_TO_MAX) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign o_irq_timeout = !w_empty && (r_idle == LP_TO_MAX);
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a queue scoreboard of stored bytes.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_end;
    logic [7:0] i_rx_data;
    logic       i_pop;
    logic [7:0] o_rd_data;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic [4:0] i_level_thr;
    logic       o_irq_level;
    logic       o_overrun;
    logic       i_ovr_clr;
    logic       i_flush;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic       o_irq_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    logic       exp_ovr;

    always #5 i_clk = ~i_clk;

    uart_rx_fifo #(
        .DEPTH  (16),
        .PTR_W  (4),
        .DATA_W (8)
`ifdef UART_RX_FIFO_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_end    (i_rx_end),
        .i_rx_data   (i_rx_data),
        .i_pop       (i_pop),
        .o_rd_data   (o_rd_data),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_count     (o_count),
        .i_level_thr (i_level_thr),
        .o_irq_level (o_irq_level),
        .o_overrun   (o_overrun),
        .i_ovr_clr   (i_ovr_clr),
        .i_flush     (i_flush)
`ifdef UART_RX_FIFO_TIMEOUT_EN
        ,
        .o_irq_timeout (o_irq_timeout)
`endif
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Stimulus helpers keep the scoreboard in step; comparisons live in the test tasks.
    task automatic push_byte(input logic [7:0] d);
        i_rx_end  = 1'b1;
        i_rx_data = d;
        tick();
        i_rx_end  = 1'b0;
        if (sb.size() < 16) sb.push_back(d);
        else exp_ovr = 1'b1;
    endtask

    task automatic pop_byte();
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_level_thr = 5'd1;
        tick();
        tick();
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", o_empty); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", o_full); end
        checks++; if (o_rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%02h exp=00", o_rd_data); end
        checks++; if (o_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", o_overrun); end
        checks++; if (o_irq_level !== 1'b0) begin failures++; $display("FAIL reset_irq_level got=%0b exp=0", o_irq_level); end
        i_reset = 1'b1;
        sb.delete();
        exp_ovr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        i_level_thr = 5'd0;
        push_byte(8'hA1);
        checks++; if (o_rd_data !== 8'hA1) begin failures++; $display("FAIL basic_first_latency got=%02h exp=a1", o_rd_data); end
        push_byte(8'hB2);
        push_byte(8'hC3);
        checks++; if (o_count !== 5'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", o_count); end
        for (int k = 0; k < 3; k++) begin
            exp = sb[0];
            checks++; if (o_rd_data !== exp) begin failures++; $display("FAIL basic_pop%0d got=%02h exp=%02h", k, o_rd_data, exp); end
            pop_byte();
        end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%0b exp=1", o_empty); end
        checks++; if (o_rd_data !== 8'h00) begin failures++; $display("FAIL basic_rd_zero got=%02h exp=00", o_rd_data); end
    endtask

    task automatic test_reset_mid();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        sb.delete();
        checks++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin failures++; $display("FAIL midreset_count got=%0d/%0b exp=0/1", o_count, o_empty); end
        push_byte(8'h77);
        checks++; if (o_rd_data !== 8'h77) begin failures++; $display("FAIL midreset_first_push got=%02h exp=77", o_rd_data); end
        pop_byte();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int k = 0; k < 16; k++) push_byte(8'(k));
        checks++; if (o_full !== 1'b1 || o_count !== 5'd16) begin failures++; $display("FAIL ovr_full got=%0b/%0d exp=1/16", o_full, o_count); end
        push_byte(8'hFF);
        checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", o_overrun); end
        checks++; if (o_count !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", o_count); end
        // Drop and clear in the same cycle: the set must win.
        i_ovr_clr = 1'b1;
        push_byte(8'hEE);
        i_ovr_clr = 1'b0;
        checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", o_overrun); end
        for (int k = 0; k < 16; k++) begin
            exp = sb[0];
            checks++; if (o_rd_data !== exp) begin failures++; $display("FAIL ovr_pop%0d got=%02h exp=%02h", k, o_rd_data, exp); end
            pop_byte();
        end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL ovr_drained got=%0b exp=1", o_empty); end
        i_ovr_clr = 1'b1;
        tick();
        i_ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", o_overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int k = 0; k < 16; k++) push_byte(8'h20 + 8'(k));
        exp = sb[0];
        checks++; if (o_rd_data !== exp) begin failures++; $display("FAIL fpp_head got=%02h exp=%02h", o_rd_data, exp); end
        i_pop = 1'b1;
        push_byte(8'h55);
        i_pop = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'h55);
        checks++; if (o_count !== 5'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", o_count); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL fpp_overrun got=%0b exp=0", o_overrun); end
        for (int k = 0; k < 16; k++) begin
            exp = sb[0];
            checks++; if (o_rd_data !== exp) begin failures++; $display("FAIL fpp_pop%0d got=%02h exp=%02h", k, o_rd_data, exp); end
            pop_byte();
        end
        // Pop while empty must be ignored.
        pop_byte();
        checks++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin failures++; $display("FAIL pop_empty got=%0d/%0b exp=0/1", o_count, o_empty); end
        // Push and pop together while empty: push accepted, pop ignored.
        i_pop = 1'b1;
        push_byte(8'h66);
        i_pop = 1'b0;
        checks++; if (o_count !== 5'd1 || o_rd_data !== 8'h66) begin failures++; $display("FAIL empty_push_pop got=%0d/%02h exp=1/66", o_count, o_rd_data); end
        pop_byte();
    endtask

    task automatic test_level();
        logic [7:0] exp;
        i_level_thr = 5'd4;
        for (int k = 0; k < 3; k++) push_byte(8'h40 + 8'(k));
        checks++; if (o_irq_level !== 1'b0) begin failures++; $display("FAIL lvl_below got=%0b exp=0", o_irq_level); end
        push_byte(8'h43);
        checks++; if (o_irq_level !== 1'b1 || o_count !== 5'd4) begin failures++; $display("FAIL lvl_at got=%0b/%0d exp=1/4", o_irq_level, o_count); end
        exp = sb[0];
        checks++; if (o_rd_data !== exp) begin failures++; $display("FAIL lvl_pop got=%02h exp=%02h", o_rd_data, exp); end
        pop_byte();
        checks++; if (o_irq_level !== 1'b0) begin failures++; $display("FAIL lvl_after_pop got=%0b exp=0", o_irq_level); end
        for (int k = 0; k < 13; k++) push_byte(8'h50 + 8'(k));
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL lvl_full got=%0b exp=1", o_full); end
        i_level_thr = 5'd0;
        #1;
        checks++; if (o_irq_level !== 1'b0) begin failures++; $display("FAIL lvl_thr0 got=%0b exp=0", o_irq_level); end
        i_level_thr = 5'd16;
        #1;
        checks++; if (o_irq_level !== 1'b1) begin failures++; $display("FAIL lvl_thr16 got=%0b exp=1", o_irq_level); end
        i_level_thr = 5'd17;
        #1;
        checks++; if (o_irq_level !== 1'b0) begin failures++; $display("FAIL lvl_thr17 got=%0b exp=0", o_irq_level); end
        i_level_thr = 5'd0;
    endtask

    task automatic test_flush();
        logic [7:0] exp;
        // FIFO is full on entry; force an overrun so flush can be seen to leave it alone.
        push_byte(8'h99);
        checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL flush_pre_ovr got=%0b exp=1", o_overrun); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        sb.delete();
        for (int k = 0; k < 5; k++) push_byte(8'h80 + 8'(k));
        i_flush = 1'b1;
        push_byte(8'hAB);
        i_flush = 1'b0;
        sb.delete();
        checks++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin failures++; $display("FAIL flush_count got=%0d/%0b exp=0/1", o_count, o_empty); end
        checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL flush_ovr_kept got=%0b exp=1", o_overrun); end
        checks++; if (o_rd_data !== 8'h00) begin failures++; $display("FAIL flush_rd_zero got=%02h exp=00", o_rd_data); end
        push_byte(8'h3C);
        exp = sb[0];
        checks++; if (o_rd_data !== exp || o_count !== 5'd1) begin failures++; $display("FAIL flush_next_push got=%02h/%0d exp=%02h/1", o_rd_data, o_count, exp); end
        pop_byte();
        i_ovr_clr = 1'b1;
        tick();
        i_ovr_clr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic       rx;
        logic       pp;
        logic [7:0] d;
        logic       do_pop;
        int         sz;
        for (int c = 0; c < 300; c++) begin
            rx = ($urandom_range(0, 9) < 7);
            pp = (c < 150) ? ($urandom_range(0, 7) < 3) : ($urandom_range(0, 7) < 7);
            d  = 8'($urandom);
            i_rx_end  = rx;
            i_rx_data = d;
            i_pop     = pp;
            sz = sb.size();
            if (pp && sz > 0) begin
                checks++; if (o_rd_data !== sb[0]) begin failures++; $display("FAIL b2b_data c=%0d got=%02h exp=%02h", c, o_rd_data, sb[0]); end
            end
            tick();
            do_pop = pp && (sz > 0);
            if (do_pop) void'(sb.pop_front());
            if (rx && (sz < 16 || do_pop)) sb.push_back(d);
            else if (rx) exp_ovr = 1'b1;
            checks++; if (o_count !== 5'(sb.size())) begin failures++; $display("FAIL b2b_count c=%0d got=%0d exp=%0d", c, o_count, sb.size()); end
        end
        i_rx_end = 1'b0;
        i_pop    = 1'b0;
        checks++; if (o_overrun !== exp_ovr) begin failures++; $display("FAIL b2b_overrun got=%0b exp=%0b", o_overrun, exp_ovr); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        sb.delete();
    endtask

`ifdef UART_RX_FIFO_TIMEOUT_EN
    task automatic test_timeout();
        push_byte(8'h5A);
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++; if (o_irq_timeout !== 1'b0) begin failures++; $display("FAIL to_early k=%0d got=%0b exp=0", k, o_irq_timeout); end
        end
        tick();
        checks++; if (o_irq_timeout !== 1'b1) begin failures++; $display("FAIL to_fire got=%0b exp=1", o_irq_timeout); end
        tick();
        tick();
        checks++; if (o_irq_timeout !== 1'b1) begin failures++; $display("FAIL to_hold got=%0b exp=1", o_irq_timeout); end
        pop_byte();
        checks++; if (o_irq_timeout !== 1'b0) begin failures++; $display("FAIL to_pop_clear got=%0b exp=0", o_irq_timeout); end
        push_byte(8'h6B);
        for (int k = 0; k < 14; k++) tick();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        sb.delete();
        checks++; if (o_irq_timeout !== 1'b0 || o_count !== 5'd0) begin failures++; $display("FAIL to_reset got=%0b/%0d exp=0/0", o_irq_timeout, o_count); end
        tick();
        checks++; if (o_irq_timeout !== 1'b0) begin failures++; $display("FAIL to_reset_hold got=%0b exp=0", o_irq_timeout); end
    endtask
`endif

    initial begin
        i_reset     = 1'b0;
        i_rx_end    = 1'b0;
        i_rx_data   = 8'h00;
        i_pop       = 1'b0;
        i_level_thr = 5'd0;
        i_ovr_clr   = 1'b0;
        i_flush     = 1'b0;
        exp_ovr     = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_overrun();
        test_full_push_pop();
        test_level();
        test_flush();
        test_back_to_back();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_fifo
